// File: rtl/ikascc_bus_pkg.sv
// ============================================================================
// ikascc_bus_pkg
// Shared types and constants for the IKASCC cartridge bus master.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ikascc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } bus_state_t;

  localparam int         c_CNT_W    = 4;
  localparam logic [1:0] c_CS_WIN_LO = 2'b01;
  localparam logic [1:0] c_CS_WIN_HI = 2'b10;
  localparam int         c_CYC_MIN  = 1;
  localparam int         c_CYC_MAX  = 15;

  // Out-of-range phase lengths are clamped rather than wrapping the counter.
  function automatic logic [c_CNT_W-1:0] cyc_load(input int n);
    if (n <= c_CYC_MIN)
      return '0;
    else if (n >= c_CYC_MAX)
      return c_CNT_W'(c_CYC_MAX - 1);
    else
      return c_CNT_W'(n - 1);
  endfunction

  function automatic logic addr_in_window(input logic [15:0] addr);
    return (addr[15:14] == c_CS_WIN_LO) || (addr[15:14] == c_CS_WIN_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ikascc_bus_timer.sv
// ============================================================================
// ikascc_bus_timer
// Loadable down-counter that times each bus phase; done when it reaches zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ikascc_bus_timer
  import ikascc_bus_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [c_CNT_W-1:0] i_load_val,
  output logic               o_done
);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ikascc_bus_master.sv
// ============================================================================
// ikascc_bus_master
// Request/acknowledge to SCC cartridge bus cycle generator with registered strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ikascc_bus_master
  import ikascc_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 1
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST_n,
  input  logic        i_REQ,
  input  logic        i_REQ_WR,
  input  logic [15:0] i_REQ_ADDR,
  input  logic [7:0]  i_REQ_DATA,
  output logic        o_ACK,
  output logic        o_BUSY,
  output logic [7:0]  o_RDATA,
  output logic        o_RDATA_VALID,
  output logic        o_CS_n,
  output logic        o_WR_n,
  output logic        o_RD_n,
  output logic [15:0] o_AB,
  output logic [7:0]  o_DB,
  output logic        o_DB_OE,
  input  logic [7:0]  i_DB
);

  localparam logic [c_CNT_W-1:0] c_SETUP_LD   = cyc_load(SETUP_CYC);
  localparam logic [c_CNT_W-1:0] c_STROBE_LD  = cyc_load(STROBE_CYC);
  localparam logic [c_CNT_W-1:0] c_HOLD_LD    = cyc_load(HOLD_CYC);
  localparam logic [c_CNT_W-1:0] c_RECOVER_LD = cyc_load(RECOVER_CYC);

  bus_state_t         r_state;
  bus_state_t         w_state_nxt;
  logic               w_load;
  logic [c_CNT_W-1:0] w_load_val;
  logic               w_done;
  logic               w_ack;

  logic               r_wr;
  logic               r_cs_n;
  logic               r_wr_n;
  logic               r_rd_n;
  logic [15:0]        r_ab;
  logic [7:0]         r_db;
  logic               r_db_oe;
  logic [7:0]         r_rdata;
  logic               r_rdata_valid;

  ikascc_bus_timer u_timer (
    .i_clk      (i_EMUCLK),
    .i_rst_n    (i_RST_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_REQ) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
          w_load_val  = c_SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_state_nxt = ST_STROBE;
          w_load      = 1'b1;
          w_load_val  = c_STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (w_done) begin
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
          w_load_val  = c_HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (w_done) begin
          w_state_nxt = ST_RECOVER;
          w_load      = 1'b1;
          w_load_val  = c_RECOVER_LD;
        end
      end
      ST_RECOVER: begin
        if (w_done)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus pins change only on phase boundaries, so each strobe is a clean register edge.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_wr          <= 1'b0;
      r_cs_n        <= 1'b1;
      r_wr_n        <= 1'b1;
      r_rd_n        <= 1'b1;
      r_ab          <= '0;
      r_db          <= '0;
      r_db_oe       <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_REQ) begin
            r_wr    <= i_REQ_WR;
            r_ab    <= i_REQ_ADDR;
            r_cs_n  <= ~addr_in_window(i_REQ_ADDR);
            r_db_oe <= i_REQ_WR;
            if (i_REQ_WR)
              r_db <= i_REQ_DATA;
          end
        end
        ST_SETUP: begin
          if (w_done) begin
            r_wr_n <= ~r_wr;
            r_rd_n <= r_wr;
          end
        end
        ST_STROBE: begin
          if (w_done) begin
            r_wr_n <= 1'b1;
            r_rd_n <= 1'b1;
            if (!r_wr) begin
              r_rdata       <= i_DB;
              r_rdata_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            r_cs_n  <= 1'b1;
            r_db_oe <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ACK         = w_ack;
  assign o_BUSY        = (r_state != ST_IDLE);
  assign o_RDATA       = r_rdata;
  assign o_RDATA_VALID = r_rdata_valid;
  assign o_CS_n        = r_cs_n;
  assign o_WR_n        = r_wr_n;
  assign o_RD_n        = r_rd_n;
  assign o_AB          = r_ab;
  assign o_DB          = r_db;
  assign o_DB_OE       = r_db_oe;

endmodule

`default_nettype wire

// File: tb/tb_ikascc_bus_master.sv
// ============================================================================
// tb_ikascc_bus_master
// Directed self-checking bench with a small bank-register mapper model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ikascc_bus_master;

  logic        clk;
  logic        rst_n;
  logic        req, req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        ack, busy, rdv, cs_n, wr_n, rd_n, db_oe;
  logic [7:0]  rdata, db, db_in, rd_val;
  logic [15:0] ab;

  logic        f_req, f_req_wr;
  logic [15:0] f_req_addr;
  logic [7:0]  f_req_data;
  logic        f_ack, f_busy, f_rdv, f_cs_n, f_wr_n, f_rd_n, f_db_oe;
  logic [7:0]  f_rdata, f_db, f_db_in;
  logic [15:0] f_ab;

  int checks = 0;
  int errors = 0;

  logic [7:0] bank [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign db_in   = !rd_n ? rd_val : 8'h00;
  assign f_db_in = 8'h00;

  ikascc_bus_master u_dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_REQ(req), .i_REQ_WR(req_wr),
    .i_REQ_ADDR(req_addr), .i_REQ_DATA(req_data), .o_ACK(ack), .o_BUSY(busy),
    .o_RDATA(rdata), .o_RDATA_VALID(rdv), .o_CS_n(cs_n), .o_WR_n(wr_n),
    .o_RD_n(rd_n), .o_AB(ab), .o_DB(db), .o_DB_OE(db_oe), .i_DB(db_in)
  );

  ikascc_bus_master #(
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)
  ) u_fast (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_REQ(f_req), .i_REQ_WR(f_req_wr),
    .i_REQ_ADDR(f_req_addr), .i_REQ_DATA(f_req_data), .o_ACK(f_ack), .o_BUSY(f_busy),
    .o_RDATA(f_rdata), .o_RDATA_VALID(f_rdv), .o_CS_n(f_cs_n), .o_WR_n(f_wr_n),
    .o_RD_n(f_rd_n), .o_AB(f_ab), .o_DB(f_db), .o_DB_OE(f_db_oe), .i_DB(f_db_in)
  );

  // Bank registers at 0x5000/0x7000/0x9000/0xB000 latch on the WR_n rising edge.
  always @(posedge wr_n or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else if (!cs_n) begin
      case (ab[15:11])
        5'h0A: bank[0] <= db;
        5'h0E: bank[1] <= db;
        5'h12: bank[2] <= db;
        5'h16: bank[3] <= db;
        default: ;
      endcase
    end
  end

  task automatic test_reset();
    logic [4:0] exp_v;
    rst_n = 1'b0; req = 0; req_wr = 0; req_addr = 0; req_data = 0; rd_val = 0;
    f_req = 0; f_req_wr = 0; f_req_addr = 0; f_req_data = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, wr_n, rd_n, db_oe, busy, ack, rdv} !== 7'b1110000 || ab !== 16'h0 ||
        db !== 8'h0 || rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_values: cs/wr/rd/oe/busy/ack/rdv=%b ab=%h db=%h rdata=%h want 1110000 0 0 0",
               {cs_n, wr_n, rd_n, db_oe, busy, ack, rdv}, ab, db, rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    // Start a write to 0x8000 and assert reset in the middle of its strobe.
    @(negedge clk); req = 1; req_wr = 1; req_addr = 16'h8000; req_data = 8'h81;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req = 0;
    end
    checks++;
    if (wr_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_prestrobe: wr_n=%b want 0", wr_n);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_v = 5'b11100;
    checks++;
    if ({cs_n, wr_n, rd_n, db_oe, busy} !== exp_v) begin
      errors++;
      $display("FAIL reset_async: cs/wr/rd/oe/busy=%b want %b", {cs_n, wr_n, rd_n, db_oe, busy}, exp_v);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || ab !== 16'h0) begin
      errors++;
      $display("FAIL reset_release: busy=%b ack=%b ab=%h want 0 0 0000", busy, ack, ab);
    end
  endtask

  // Runs one default-timing cycle and checks every clock against the fixed timeline.
  task automatic run_cycle(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                           input logic exp_cs_active, input string name);
    logic [4:0] exp_v;
    logic       in_bus;
    @(negedge clk); req = 1; req_wr = wr; req_addr = addr; req_data = data;
    #1;
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: ack=%b busy=%b want 1 0", name, ack, busy);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req = 0;
      #1;
      in_bus = (k >= 1 && k <= 8);
      exp_v[4] = !(in_bus && exp_cs_active);
      exp_v[3] = !(wr && k >= 3 && k <= 6);
      exp_v[2] = !(!wr && k >= 3 && k <= 6);
      exp_v[1] = wr && in_bus;
      exp_v[0] = (k <= 9);
      checks++;
      if ({cs_n, wr_n, rd_n, db_oe, busy} !== exp_v) begin
        errors++;
        $display("FAIL %s_cyc%0d: cs/wr/rd/oe/busy=%b want %b", name, k, {cs_n, wr_n, rd_n, db_oe, busy}, exp_v);
      end
      checks++;
      if (ab !== addr || (wr && in_bus && db !== data)) begin
        errors++;
        $display("FAIL %s_bus%0d: ab=%h db=%h want %h %h", name, k, ab, db, addr, data);
      end
      checks++;
      if (rdv !== (!wr && k == 7)) begin
        errors++;
        $display("FAIL %s_rdv%0d: rdv=%b want %b", name, k, rdv, (!wr && k == 7));
      end
    end
  endtask

  task automatic test_write();
    run_cycle(1'b1, 16'h9000, 8'h3F, 1'b1, "write");
    checks++;
    if (bank[2] !== 8'h3F || bank[0] !== 8'h00) begin
      errors++;
      $display("FAIL write_mapper: bank2=%h bank0=%h want 3f 00", bank[2], bank[0]);
    end
  endtask

  task automatic test_read();
    rd_val = 8'hA5;
    run_cycle(1'b0, 16'h9800, 8'h00, 1'b1, "read");
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_data: rdata=%h want a5", rdata);
    end
    rd_val = 8'h00;
  endtask

  task automatic test_out_of_window();
    run_cycle(1'b1, 16'hC000, 8'h77, 1'b0, "oow");
    checks++;
    if (bank[0] !== 8'h00 || bank[1] !== 8'h00 || bank[2] !== 8'h3F || bank[3] !== 8'h00) begin
      errors++;
      $display("FAIL oow_mapper: banks=%h %h %h %h want 00 00 3f 00", bank[0], bank[1], bank[2], bank[3]);
    end
  endtask

  task automatic test_busy_change();
    @(negedge clk); req = 1; req_wr = 1; req_addr = 16'h7000; req_data = 8'h5C;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req = 0;
      if (k == 2) begin req_wr = 0; req_addr = 16'hB000; req_data = 8'hEE; end
      if (k == 4) req = 1;
      if (k == 9) req = 0;
      #1;
      if (k >= 2 && k <= 8) begin
        checks++;
        if (ab !== 16'h7000 || db !== 8'h5C || db_oe !== 1'b1 || ack !== 1'b0 ||
            wr_n !== !(k >= 3 && k <= 6) || rd_n !== 1'b1) begin
          errors++;
          $display("FAIL busy_hold%0d: ab=%h db=%h oe=%b ack=%b wr=%b rd=%b want 7000 5c 1 0 %b 1",
                   k, ab, db, db_oe, ack, wr_n, rd_n, !(k >= 3 && k <= 6));
        end
      end
    end
    checks++;
    if (bank[1] !== 8'h5C) begin
      errors++;
      $display("FAIL busy_mapper: bank1=%h want 5c", bank[1]);
    end
    run_cycle(1'b0, 16'hB000, 8'hEE, 1'b1, "newreq");
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    logic [7:0]  datas [3];
    int          idx;
    logic [2:0]  exp_v;
    addrs[0] = 16'h5000; addrs[1] = 16'h7000; addrs[2] = 16'h9000;
    datas[0] = 8'h11;    datas[1] = 8'h22;    datas[2] = 8'h33;
    @(negedge clk); f_req = 1; f_req_wr = 1; f_req_addr = addrs[0]; f_req_data = datas[0];
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      idx = k / 5;
      if (k % 5 == 1) begin
        if (idx + 1 < 3) begin
          f_req_addr = addrs[idx + 1]; f_req_data = datas[idx + 1];
        end else begin
          f_req = 0;
        end
      end
      #1;
      exp_v[2] = (k % 5 == 0) && (k < 15);
      exp_v[1] = !((k % 5 == 2) && (k < 15));
      exp_v[0] = (k % 5 >= 1) && (k % 5 <= 3) && (k < 15);
      checks++;
      if ({f_ack, f_wr_n, f_db_oe} !== exp_v || f_rd_n !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cyc%0d: ack/wr/oe=%b rd=%b want %b 1", k, {f_ack, f_wr_n, f_db_oe}, f_rd_n, exp_v);
      end
      if (exp_v[0]) begin
        checks++;
        if (f_db !== datas[idx] || f_ab !== addrs[idx] || f_cs_n !== 1'b0) begin
          errors++;
          $display("FAIL b2b_bus%0d: ab=%h db=%h cs=%b want %h %h 0", k, f_ab, f_db, f_cs_n, addrs[idx], datas[idx]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_window();
    test_busy_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ikascc_bus_master.md
Name: ikascc_bus_master

Overview:
- Clocked bus-cycle generator that drives the cartridge-side SCC mapper/sound bus (CS_n, WR_n, RD_n, address, data) from a simple request/acknowledge host interface.
- Sits between the host controller (register-write sequencer, ROM reader) and the IKASCC mapper.
- Writes bank registers and SCC sound registers, and reads ROM/SCC data.
- Every bus strobe is registered and glitch-free, because the mapper latches bank registers on the rising edge of WR_n.

Parameters:
SETUP_CYC, 2, clocks from address/CS_n/data valid to strobe low (1..15)
STROBE_CYC, 4, clocks WR_n or RD_n held low (1..15)
HOLD_CYC, 2, clocks address/CS_n/data held after strobe high (1..15)
RECOVER_CYC, 1, clocks CS_n high and data bus released before the next cycle (1..15)

Ports:
i_EMUCLK  in  1  system clock
i_RST_n  in  1  asynchronous active-low reset
i_REQ  in  1  request valid; held until o_ACK
i_REQ_WR  in  1  1 = write cycle, 0 = read cycle
i_REQ_ADDR  in  16  bus address
i_REQ_DATA  in  8  write data
o_ACK  out  1  one-clock pulse when the request is accepted
o_BUSY  out  1  high in any state other than IDLE
o_RDATA  out  8  last read data
o_RDATA_VALID  out  1  one-clock pulse when o_RDATA updates
o_CS_n  out  1  slot/chip select, active low
o_WR_n  out  1  write strobe
o_RD_n  out  1  read strobe
o_AB  out  16  address bus
o_DB  out  8  write data bus
o_DB_OE  out  1  data bus output enable
i_DB  in  8  read data bus

Behaviour:
- Reset is asynchronous and active low. Reset values:
  - o_CS_n, o_WR_n, o_RD_n = 1
  - o_AB = 0, o_DB = 0, o_DB_OE = 0
  - o_ACK = 0, o_BUSY = 0, o_RDATA = 0, o_RDATA_VALID = 0
  - state = IDLE, counter = 0
- Reset asserted mid-cycle returns all strobes high immediately. The WR_n edge this produces is acceptable because the mapper shares the reset.
- All bus outputs come from registers. No combinational path runs from inputs to bus outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. A 4-bit down-counter is loaded with (N-1) on entry to each timed state.
- IDLE:
  - If i_REQ=1, pulse o_ACK in the same cycle and latch WR/ADDR/DATA. Go to SETUP.
  - If i_REQ=0, nothing changes.
- SETUP (SETUP_CYC clocks):
  - o_AB = latched address.
  - o_CS_n = 0 only if ADDR[15:14] is 01 or 10 (window 0x4000–0xBFFF). Otherwise o_CS_n stays 1, but the full cycle still runs.
  - For a write: o_DB = data and o_DB_OE = 1.
  - Strobes stay high.
- STROBE (STROBE_CYC clocks):
  - Write: o_WR_n = 0. Read: o_RD_n = 0.
  - Address, CS_n and data are unchanged.
  - For a read, i_DB is captured into o_RDATA on the last STROBE clock. o_RDATA_VALID pulses in the first HOLD clock.
- HOLD (HOLD_CYC clocks): strobes high; address, CS_n, DB and OE unchanged. This guarantees data is stable across the WR_n rising edge.
- RECOVER (RECOVER_CYC clocks): o_CS_n = 1, o_DB_OE = 0, o_AB held. Then go to IDLE.
- Latency, with ACK in clock t:
  - Bus valid from t+1.
  - Strobe low from t+SETUP_CYC+1 through t+SETUP_CYC+STROBE_CYC.
  - IDLE (next ACK possible) at t+S+W+H+R+1. With default parameters this is t+10.
- Back-to-back requests: i_REQ held continuously is accepted once per cycle period. There is no pipelining.
- Request inputs are ignored outside IDLE. Only the latched copy is used.
- o_RD_n and o_WR_n are never low at the same time. At most one strobe is active per cycle.

Decomposition:
- Package ikascc_bus_pkg holds:
  - the state enumeration
  - the counter width (4)
  - the CS window constants (2'b01, 2'b10 on A15:A14)
  - the parameter range limits
- One sub-module, ikascc_bus_timer: 4-bit loadable down-counter with a load input and a done flag, used for all timed states.

Test Plan:
- Reset check: apply reset mid-STROBE of a write → all strobes high and OE low asynchronously; after release the FSM is in IDLE and o_BUSY=0.
- Default-parameter write, addr 0x9000 data 0x3F → ACK at t, CS_n low t+1..t+8, WR_n low t+3..t+6, DB=0x3F with OE=1 t+1..t+8, next ACK at t+10. Mapper model shows bankreg2=0x3F.
- Read of addr 0x9800 with the bus model returning 0xA5 → RD_n low for 4 clocks, o_RDATA=0xA5 and a 1-clock o_RDATA_VALID pulse at the first HOLD clock, WR_n stays high.
- Out-of-window write to 0xC000 → full timing with o_CS_n held at 1 throughout; mapper registers unchanged.
- Parameters 1/1/1/1 with i_REQ held for 3 requests → ACK every 5 clocks, 1-clock strobes, o_DB stable one clock past the WR_n rise.
- i_REQ_ADDR/DATA changed while BUSY → bus outputs keep the latched values; the new values are used only at the next ACK.
